// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the 3x3 convolution datapath.
// Helpers work on a 64-bit signed intermediate so they serve any configured width.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        OUT
    } state_e;

    function automatic int unsigned acc_bw(input int unsigned bw_act, input int unsigned bw_w,
                                           input int unsigned taps, input int unsigned groups);
        return bw_act + bw_w + $clog2(taps) + $clog2(groups);
    endfunction

    // Round-half-up arithmetic right shift; shift of 0 passes the value through.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                       input logic [4:0] sh);
        logic signed [63:0] half;
        if (sh == 5'd0) return v;
        half = 64'sd1 <<< (sh - 5'd1);
        return (v + half) >>> sh;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned bw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered signed sum of N packed products, with a valid bit travelling alongside.
module conv_adder_tree #(
    parameter int unsigned N  = 36,
    parameter int unsigned IW = 18,
    parameter int unsigned OW = IW + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [N*IW-1:0]      prod_i,
    output logic                 valid_o,
    output logic signed [OW-1:0] sum_o
);

    logic signed [OW-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum_d = sum_d + OW'($signed(prod_i[i*IW +: IW]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            sum_o   <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) sum_o <= sum_d;
        end
    end

endmodule

// File: rtl/conv3x3_mac_engine.sv
// 3x3 MAC engine: per-beat products (P1), adder tree (P2), group accumulator,
// then bias / rounding shift / ReLU / saturation into a valid-ready output register.
module conv3x3_mac_engine
    import conv_pkg::*;
#(
    parameter int unsigned CH_NUM        = 4,
    parameter int unsigned ACT_PER_ADDR  = 9,
    parameter int unsigned BW_PER_ACT    = 10,
    parameter int unsigned BW_PER_WEIGHT = 8,
    parameter int unsigned BW_PER_BIAS   = 8,
    parameter int unsigned MAX_GROUPS    = 256
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            cfg_start,
    input  logic [$clog2(MAX_GROUPS)-1:0]                   cfg_groups_m1,
    input  logic [4:0]                                      cfg_shift,
    input  logic                                            cfg_relu,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0]       in_act,
    input  logic [CH_NUM*ACT_PER_ADDR*BW_PER_WEIGHT-1:0]    in_weight,
    input  logic [BW_PER_BIAS-1:0]                          in_bias,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [BW_PER_ACT-1:0]                           out_data,
    output logic                                            out_sat,
    output logic                                            busy
);

    localparam int unsigned N      = CH_NUM * ACT_PER_ADDR;
    localparam int unsigned PW     = BW_PER_ACT + BW_PER_WEIGHT;
    localparam int unsigned SW     = PW + $clog2(N);
    localparam int unsigned ACC_BW = acc_bw(BW_PER_ACT, BW_PER_WEIGHT, N, MAX_GROUPS);
    localparam int unsigned GW     = $clog2(MAX_GROUPS);

    state_e                      state_q, state_d;
    logic [GW-1:0]               groups_q;
    logic [GW-1:0]               beat_cnt_q, beat_cnt_d;
    logic [4:0]                  shift_q;
    logic                        relu_q;
    logic signed [BW_PER_BIAS-1:0] bias_q;
    logic signed [ACC_BW-1:0]    acc_q, acc_d;
    logic [N*PW-1:0]             prod_q, prod_d;
    logic                        p1_v_q;
    logic                        p2_v;
    logic signed [SW-1:0]        p2_sum;
    logic [BW_PER_ACT-1:0]       out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d;
    logic                        start, accept, pipe_empty;
    logic signed [63:0]          r_wide, r_rnd, r_act, r_sat;

    assign start      = (state_q == IDLE) && cfg_start;
    assign accept     = (state_q == ACCUM) && in_valid;
    assign pipe_empty = !p1_v_q && !p2_v;

    always_comb begin
        prod_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            prod_d[i*PW +: PW] = PW'($signed(in_act[i*BW_PER_ACT +: BW_PER_ACT]))
                               * PW'($signed(in_weight[i*BW_PER_WEIGHT +: BW_PER_WEIGHT]));
        end
    end

    conv_adder_tree #(
        .N  (N),
        .IW (PW),
        .OW (SW)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .valid_i (p1_v_q),
        .prod_i  (prod_q),
        .valid_o (p2_v),
        .sum_o   (p2_sum)
    );

    always_comb begin
        acc_d = acc_q;
        if (start)     acc_d = '0;
        else if (p2_v) acc_d = acc_q + ACC_BW'(p2_sum);
    end

    // Post-processing reads the accumulator only once the pipeline has fully drained.
    always_comb begin
        r_wide = 64'(acc_q) + 64'(bias_q);
        r_rnd  = round_shift(r_wide, shift_q);
        r_act  = (relu_q && r_rnd < 0) ? 64'sd0 : r_rnd;
        r_sat  = saturate(r_act, BW_PER_ACT);
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d    = ACCUM;
                    beat_cnt_d = '0;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == groups_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    out_data_d = r_sat[BW_PER_ACT-1:0];
                    out_sat_d  = (r_sat != r_act);
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            groups_q   <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            bias_q     <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            p1_v_q     <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            p1_v_q     <= accept;
            if (accept) prod_q <= prod_d;
            if (start) begin
                groups_q <= cfg_groups_m1;
                shift_q  <= cfg_shift;
                relu_q   <= cfg_relu;
            end
            if (accept && beat_cnt_q == '0) bias_q <= in_bias;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv3x3_mac_engine.sv
// Randomised self-checking bench for conv3x3_mac_engine against a plain-arithmetic model.
module tb_conv3x3_mac_engine;

    localparam int N   = 36;
    localparam int BA  = 10;
    localparam int BWT = 8;
    localparam int BB  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic [7:0]        cfg_groups_m1 = '0;
    logic [4:0]        cfg_shift = '0;
    logic              cfg_relu = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*BA-1:0]   in_act = '0;
    logic [N*BWT-1:0]  in_weight = '0;
    logic [BB-1:0]     in_bias = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BA-1:0]     out_data;
    logic              out_sat;
    logic              busy;

    conv3x3_mac_engine #(
        .CH_NUM        (4),
        .ACT_PER_ADDR  (9),
        .BW_PER_ACT    (BA),
        .BW_PER_WEIGHT (BWT),
        .BW_PER_BIAS   (BB),
        .MAX_GROUPS    (256)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_groups_m1 (cfg_groups_m1),
        .cfg_shift     (cfg_shift),
        .cfg_relu      (cfg_relu),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_act        (in_act),
        .in_weight     (in_weight),
        .in_bias       (in_bias),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_sat       (out_sat),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     hs_cnt = 0;
    int     last_hs_edge = 0;
    logic   prev_valid = 1'b0;
    longint exp_data = 0;
    logic   exp_sat = 1'b0;
    longint last_out = 0;
    logic   last_sat = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Compare process: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            hs_cnt++;
            last_hs_edge = cyc + 1;
        end
        if (!rst && out_valid) begin
            chk("out_data", longint'($signed(out_data)), exp_data);
            chk("out_sat", longint'(out_sat), longint'(exp_sat));
            chk("busy_in_out", longint'(busy), 1);
            if (!prev_valid) chk("latency", cyc - last_hs_edge, 3);
            last_out = longint'($signed(out_data));
            last_sat = out_sat;
        end
        prev_valid = out_valid;
    end

    task automatic set_const(input int a, input int w);
        for (int k = 0; k < N; k++) begin
            in_act[k*BA +: BA]     = BA'(a);
            in_weight[k*BWT +: BWT] = BWT'(w);
        end
    endtask

    // Runs one full output; called at #1 after a rising edge with the engine idle.
    task automatic run_op(input int gm1, input int sh, input bit relu, input bit rnd,
                          input int aval, input int wval, input int bias,
                          input int gap, input int hold);
        longint acc_m;
        longint r;
        int     a;
        int     w;
        acc_m  = 0;
        hs_cnt = 0;
        cfg_start     = 1'b1;
        cfg_groups_m1 = 8'(gm1);
        cfg_shift     = 5'(sh);
        cfg_relu      = relu;
        @(posedge clk); #1;
        cfg_start     = 1'b0;
        cfg_groups_m1 = 8'($urandom);
        cfg_shift     = 5'($urandom);
        cfg_relu      = ~relu;
        chk("in_ready_after_start", longint'(in_ready), 1);
        chk("busy_after_start", longint'(busy), 1);
        for (int b = 0; b <= gm1; b++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 1'b0;
                in_bias  = BB'($urandom);
                @(posedge clk); #1;
            end
            for (int k = 0; k < N; k++) begin
                a = rnd ? int'($urandom_range(1023)) - 512 : aval;
                w = rnd ? int'($urandom_range(255)) - 128 : wval;
                acc_m += longint'(a) * longint'(w);
                in_act[k*BA +: BA]      = BA'(a);
                in_weight[k*BWT +: BWT] = BWT'(w);
            end
            in_bias = (b == 0) ? BB'(bias) : BB'($urandom);
            if (b == gm1) begin
                r = acc_m + longint'(bias);
                if (sh > 0) r = (r + (longint'(1) << (sh - 1))) >>> sh;
                if (relu && r < 0) r = 0;
                exp_sat = 1'b1;
                if (r > 511) r = 511;
                else if (r < -512) r = -512;
                else exp_sat = 1'b0;
                exp_data = r;
            end
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("in_ready_drain", longint'(in_ready), 0);
        for (int c = 0; c < 40 && !out_valid; c++) @(negedge clk);
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            cfg_start = (h == 1);
            chk("hold_out_valid", longint'(out_valid), 1);
            chk("hold_busy", longint'(busy), 1);
        end
        cfg_start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_out_valid", longint'(out_valid), 0);
        chk("idle_busy", longint'(busy), 0);
        chk("beats_accepted", hs_cnt, gm1 + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_sat", longint'(out_sat), 0);
        chk("rst_busy", longint'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(0, 0, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        chk("model_ones", exp_data, 36);
        chk("lit_ones", last_out, 36);
        chk("lit_ones_sat", longint'(last_sat), 0);

        run_op(0, 3, 1'b0, 1'b0, -1, 1, 0, 0, 0);
        chk("lit_neg_shift", last_out, -4);
        run_op(0, 3, 1'b1, 1'b0, -1, 1, 0, 0, 0);
        chk("lit_neg_relu", last_out, 0);

        run_op(3, 0, 1'b0, 1'b0, 511, 127, 127, 0, 0);
        chk("lit_pos_sat", last_out, 511);
        chk("lit_pos_sat_flag", longint'(last_sat), 1);
        run_op(3, 0, 1'b0, 1'b0, -512, 127, 127, 0, 0);
        chk("lit_neg_sat", last_out, -512);
        chk("lit_neg_sat_flag", longint'(last_sat), 1);

        run_op(255, 4, 1'b0, 1'b0, 1, 1, -5, 30, 0);
        chk("lit_256_groups", last_out, 511);
        chk("lit_256_groups_sat", longint'(last_sat), 1);

        run_op(2, 2, 1'b0, 1'b1, 0, 0, int'($urandom_range(255)) - 128, 0, 5);

        // Abort after 2 of 4 beats; no residue may leak into the next output.
        cfg_start = 1'b1; cfg_groups_m1 = 8'd3; cfg_shift = 5'd0; cfg_relu = 1'b0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        set_const(7, 5);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", longint'(in_ready), 0);
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_busy", longint'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(0, 0, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        chk("lit_after_abort", last_out, 36);

        repeat (20) begin
            run_op(int'($urandom_range(7)), int'($urandom_range(31)), 1'($urandom_range(1)), 1'b1,
                   0, 0, int'($urandom_range(255)) - 128, 20, int'($urandom_range(3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
